// File: rtl/mmbmp_plotter_if.sv
// Host command channel and shared screen-RAM port for the bitmap plotter.
// The slave modport is the plotter's view; master is the host/arbiter side.
interface mmbmp_plotter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [7:0]  cmd_fill;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_fill, mem_gnt, mem_rdata,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_fill, mem_gnt, mem_rdata,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mmbmp_plotter.sv
// Pixel set/clear/toggle via read-modify-write and clear-screen fill into the
// 320x240 1bpp screen RAM, sharing the RAM port through a request/grant handshake.
module mmbmp_plotter (
  input  logic           clk,
  input  logic           rst,
  mmbmp_plotter_if.slave bus,
  output logic           busy,
  output logic           err
);
  localparam int unsigned AW       = 16;
  localparam int unsigned DW       = 8;
  localparam int unsigned LAST_COL = 39;
  localparam logic [8:0]    X_LIM     = 9'd320;
  localparam logic [7:0]    Y_LIM     = 8'd240;
  localparam logic [AW-1:0] LAST_ADDR = AW'(16'h77A7);

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_CLS   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_CLS_WR  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    op_q, op_nxt;
  logic [DW-1:0] mask_q, mask_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          ready_q, ready_nxt;
  logic          req_q, req_nxt;
  logic          we_q, we_nxt;
  logic          busy_q, busy_nxt;
  logic          err_q, err_nxt;

  logic          accept, is_cls, in_range, last_addr;
  logic [AW-1:0] pixel_addr, cls_next;

  function automatic logic [DW-1:0] modify(input logic [1:0] op,
                                           input logic [DW-1:0] d,
                                           input logic [DW-1:0] m);
    case (op)
      OP_SET:   modify = d | m;
      OP_CLEAR: modify = d & ~m;
      default:  modify = d ^ m;
    endcase
  endfunction

  assign accept     = bus.cmd_valid && ready_q;
  assign is_cls     = (bus.cmd_op == OP_CLS);
  assign in_range   = (bus.cmd_x < X_LIM) && (bus.cmd_y < Y_LIM);
  assign last_addr  = (addr_q == LAST_ADDR);
  // {0, line[7:0], 0, byte column}: line pair in [14:8], odd line in [7]
  assign pixel_addr = {1'b0, bus.cmd_y, 1'b0, bus.cmd_x[8:3]};

  // CLS walk: column 0..39, then half, then row
  always_comb begin
    cls_next = addr_q;
    if (addr_q[5:0] == 6'(LAST_COL)) begin
      cls_next[5:0] = 6'd0;
      cls_next[7]   = ~addr_q[7];
      if (addr_q[7]) cls_next[14:8] = addr_q[14:8] + 7'd1;
    end else begin
      cls_next[5:0] = addr_q[5:0] + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_cls)        state_nxt = S_CLS_WR;
          else if (in_range) state_nxt = S_RD;
        end
      end
      S_RD:      if (bus.mem_gnt) state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = S_WR;
      S_WR:      if (bus.mem_gnt) state_nxt = S_IDLE;
      S_CLS_WR:  if (bus.mem_gnt && last_addr) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and datapath holding registers
  always_comb begin
    op_nxt    = op_q;
    mask_nxt  = mask_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    err_nxt   = 1'b0;
    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    req_nxt   = (state_nxt == S_RD) || (state_nxt == S_WR) || (state_nxt == S_CLS_WR);
    we_nxt    = (state_nxt == S_WR) || (state_nxt == S_CLS_WR);
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_cls) begin
            addr_nxt  = '0;
            wdata_nxt = bus.cmd_fill;
          end else if (in_range) begin
            op_nxt   = bus.cmd_op;
            mask_nxt = DW'(1) << bus.cmd_x[2:0];
            addr_nxt = pixel_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_RD_DATA: wdata_nxt = modify(op_q, bus.mem_rdata, mask_q);
      S_CLS_WR:  if (bus.mem_gnt && !last_addr) addr_nxt = cls_next;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_SET;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_nxt;
      mask_q  <= mask_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ready_q <= ready_nxt;
      req_q   <= req_nxt;
      we_q    <= we_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign err           = err_q;
endmodule

// File: tb/tb_mmbmp_plotter.sv
// Scoreboard bench for mmbmp_plotter: stimulus queues expected RAM accesses,
// an independent monitor pops and compares them on every granted request.
module tb_mmbmp_plotter;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  typedef struct {
    logic [1:0]  op;
    int          x;
    int          y;
    logic [7:0]  rd;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [63:0] lm;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  mmbmp_plotter_if bus ();

  mmbmp_plotter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned writes_seen = 0;
  txn_t        exp_q[$];
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every granted access must match the head of the expected queue
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
        if (bus.mem_we === 1'b1) writes_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_access: we=%0b addr=0x%0h wdata=0x%0h, nothing expected",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          if (e.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_req"},   32'(bus.mem_req),   32'd0);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_err"},   32'(err),           32'd0);
  endtask

  // rdata is only meaningful in the cycle after a granted read; junk otherwise
  task automatic run_pixel(input vec_t v);
    int   n;
    logic rd_grant;
    check("ready_before", 32'(bus.cmd_ready), 32'd1);
    exp_q.push_back('{we: 1'b0, addr: v.a, data: 8'h00});
    exp_q.push_back('{we: 1'b1, addr: v.a, data: v.wd});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_x     = 9'(v.x);
    bus.cmd_y     = 8'(v.y);
    bus.mem_gnt   = 1'b0;
    bus.mem_rdata = 8'hEE;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 1;
    bus.mem_gnt = ~v.lm[1];
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      if (bus.mem_req === 1'b1) check("addr_hold", 32'(bus.mem_addr), 32'(v.a));
      rd_grant = bus.mem_req && bus.mem_gnt && !bus.mem_we;
      @(posedge clk); #1;
      n++;
      bus.mem_rdata = rd_grant ? v.rd : 8'hEE;
      bus.mem_gnt   = (n < 64) ? ~v.lm[n[5:0]] : 1'b1;
    end
    check("pixel_latency", 32'(n), 32'(v.lat));
    check("pixel_pending", 32'(exp_q.size()), 32'd0);
    bus.mem_gnt = 1'b1;
  endtask

  task automatic run_drop(input logic [1:0] op, input int x, input int y);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = 9'(x);
    bus.cmd_y     = 8'(y);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("drop_err_pulse", 32'(err), 32'd1);
    check("drop_ready", 32'(bus.cmd_ready), 32'd1);
    check("drop_req", 32'(bus.mem_req), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("drop_err_clear", 32'(err), 32'd0);
    check("drop_req_after", 32'(bus.mem_req), 32'd0);
  endtask

  task automatic run_cls(input logic [7:0] fill, input bit rnd, input int exp_cycles,
                         input int abort_at);
    int          n;
    int          k;
    int          limit;
    int unsigned w0;
    limit = (abort_at > 0) ? abort_at : 9600;
    k = 0;
    for (int row = 0; row < 120; row++)
      for (int half = 0; half < 2; half++)
        for (int col = 0; col < 40; col++) begin
          if (k < limit)
            exp_q.push_back('{we: 1'b1, addr: 16'(row * 256 + half * 128 + col), data: fill});
          k++;
        end
    w0 = writes_seen;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    bus.cmd_x     = 9'h1FF;
    bus.cmd_y     = 8'hFF;
    bus.cmd_fill  = fill;
    bus.mem_gnt   = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 1;
    check("cls_busy", 32'(busy), 32'd1);
    check("cls_no_err", 32'(err), 32'd0);
    bus.mem_gnt = rnd ? 1'($urandom) : 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at - 1) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_req_idle", 32'(bus.mem_req), 32'd0);
    end else begin
      while (busy === 1'b1 && n < 40000) begin
        @(posedge clk); #1;
        n++;
        if (rnd) bus.mem_gnt = 1'($urandom);
      end
      check("cls_done", 32'(busy), 32'd0);
      check("cls_ready", 32'(bus.cmd_ready), 32'd1);
      check("cls_last_addr", 32'(bus.mem_addr), 32'h77A7);
      if (exp_cycles > 0) check("cls_cycles", 32'(n), 32'(exp_cycles));
    end
    check("cls_write_count", writes_seen - w0, 32'(limit));
    check("cls_pending", 32'(exp_q.size()), 32'd0);
    bus.mem_gnt = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_fill  = '0;
    bus.mem_gnt   = 1'b0;
    bus.mem_rdata = '0;

    // op, x, y, rdata, addr, wdata, gnt-low cycle mask, cycles to ready
    vecs[0] = '{2'd0, 162, 107, 8'hA0, 16'h3594, 8'hA4, 64'h0,   4};
    vecs[1] = '{2'd1,   7,   0, 8'hFF, 16'h0000, 8'h7F, 64'h0,   4};
    vecs[2] = '{2'd2, 319, 239, 8'h80, 16'h77A7, 8'h00, 64'h0,   4};
    vecs[3] = '{2'd1, 100,  50, 8'hFF, 16'h190C, 8'hEF, 64'h73E, 12};
    vecs[4] = '{2'd0,   0,   1, 8'h01, 16'h0080, 8'h01, 64'h0,   4};
    vecs[5] = '{2'd2,  10,   2, 8'h04, 16'h0101, 8'h00, 64'h0,   4};
    vecs[6] = '{2'd0, 200, 120, 8'h00, 16'h3C19, 8'h01, 64'h0,   4};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_pixel(vecs[i]);

    run_drop(2'd0, 320, 5);
    run_drop(2'd0, 5, 240);
    run_drop(2'd2, 511, 255);
    run_drop(2'd1, 319, 240);

    run_cls(8'h55, 1'b1, 0, 0);
    run_cls(8'hC3, 1'b0, 9601, 0);
    run_pixel(vecs[6]);

    run_cls(8'hAA, 1'b0, 0, 100);
    run_pixel(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmbmp_plotter.md
# mmbmp_plotter

Write-side companion of the memory-mapped bitmap display path. Accepts single-pixel plot commands (set/clear/toggle) and a clear-screen command from the host. Each pixel command is executed as a read-modify-write of the corresponding byte in screen memory, using the same 320x240, 1-bit-per-pixel byte layout that the bitmap display controller reads. It shares the screen RAM port with the display through a request/grant handshake.

## Interface
- No parameters; geometry is fixed at 320x240 pixels, 40 bytes per line.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  plotter can accept a command
- cmd_op  in  2  0=SET, 1=CLEAR, 2=TOGGLE, 3=CLS
- cmd_x  in  9  pixel column, 0..319
- cmd_y  in  8  pixel line, 0..239
- cmd_fill  in  8  byte written everywhere by CLS
- mem_req  out  1  memory access request, registered
- mem_gnt  in  1  access granted this cycle (the display arbiter has priority)
- mem_we  out  1  1=write, 0=read; valid with mem_req
- mem_addr  out  16  byte address, registered
- mem_wdata  out  8  write data, registered
- mem_rdata  in  8  read data, valid the cycle after a granted read
- busy  out  1  FSM not in IDLE
- err  out  1  one-cycle pulse when a command is dropped as out of range

## Operation
- Address map for pixel (x,y): mem_addr = {1'b0, y[7:1], y[0], 1'b0, x[8:3]}. Bit index is x[2:0], with bit 0 the leftmost pixel of the byte. mask = 1 << x[2:0].
- Range check applies to SET, CLEAR and TOGGLE:
  - If x>=320 or y>=240, the command is accepted and dropped.
  - err pulses for 1 cycle. No memory access occurs.
  - The FSM stays in IDLE.
- Modify rules, with d = captured rdata:
  - SET: d | mask
  - CLEAR: d & ~mask
  - TOGGLE: d ^ mask
- CLS ignores cmd_x and cmd_y. It writes cmd_fill (latched at accept) to every valid byte:
  - Order: row 0..119 (mem_addr[14:8]), then half 0..1 (mem_addr[7]), then col 0..39 (mem_addr[5:0]).
  - Total 9600 writes. First address 0x0000, last 0x77A7.
  - Bytes with col 40..63 or bit 6 set are never written.
- State machine:
  - IDLE: cmd_ready=1. On accept of an in-range pixel op, latch op, address and mask, then go to RD.
  - IDLE: on accept of CLS, latch fill, clear the address counter, then go to CLS_WR.
  - RD: mem_req=1, mem_we=0. On mem_gnt, go to RD_DATA.
  - RD_DATA: capture mem_rdata, compute wdata, go to WR.
  - WR: mem_req=1, mem_we=1. On mem_gnt, go to IDLE.
  - CLS_WR: mem_req=1, mem_we=1. On each mem_gnt, advance the counter. On the grant of the last address, go to IDLE.
- cmd_ready=0 in every state except IDLE. Commands are never queued.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_gnt=0.

## Timing
- Reset values: cmd_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err=0; FSM in IDLE.
- Reset mid-operation:
  - Aborts at the next edge. mem_req=0 the following cycle.
  - No write is issued after reset is sampled.
  - A byte already written by an interrupted CLS stays written.
- Pixel op with mem_gnt held at 1:
  - Accept at cycle 0. Read granted at cycle 1. Data captured at cycle 2. Write granted at cycle 3.
  - cmd_ready=1 again at cycle 4. Throughput is 1 pixel per 4 cycles.
- Each cycle with mem_gnt=0 while in RD, WR or CLS_WR adds exactly one cycle of latency.
- CLS with mem_gnt=1 takes 9600 cycles from first mem_req to return to IDLE.
- err is asserted in the cycle after the accept edge.
- A rejected command costs 1 cycle, and cmd_ready stays 1.
- mem_gnt is ignored whenever mem_req=0.

## Test plan
- SET x=162, y=107, mem_rdata=0xA0, gnt tied high -> read at 0x3594, write 0xA4 to 0x3594 on cycle 3, cmd_ready back on cycle 4.
- CLEAR x=7, y=0, rdata=0xFF -> address 0x0000, wdata 0x7F. TOGGLE x=319, y=239, rdata=0x80 -> address 0x77A7, wdata 0x00.
- gnt low for 5 cycles during RD and 3 cycles during WR -> addr and we stable while waiting, total latency 12 cycles, exactly one read and one write.
- x=320, y=5 SET -> err pulse of 1 cycle, no mem_req, cmd_ready stays 1. Same result for y=240.
- CLS fill=0x55 with random gnt -> exactly 9600 writes, all 0x55, in the specified order. No address with col>=40 or bit6=1. Ends at 0x77A7, then IDLE.
- rst asserted on the 100th CLS write -> mem_req=0 the next cycle, no further writes, all outputs at reset values.
